// File: rtl/alu_mem_controller_if.sv
// Bus bundle between alu_mem_controller and its environment.
// slave  : controller side (accepts commands, initiates memory/ALU traffic)
// master : environment side (issues commands, models memory and ALU)
interface alu_mem_controller_if #(
  parameter int MEM_ADDR_W = 4,
  parameter int MEM_DATA_W = 16,
  parameter int ALU_W      = 8
);
  // command channel
  logic                  start;
  logic [2:0]            cmd_opcode;
  logic [MEM_ADDR_W-1:0] cmd_src_a;
  logic [MEM_ADDR_W-1:0] cmd_src_b;
  logic [MEM_ADDR_W-1:0] cmd_dst;
  // status
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [ALU_W-1:0]      result;
  // data memory port
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [MEM_DATA_W-1:0] mem_wdata;
  logic                  mem_we;
  logic [MEM_DATA_W-1:0] mem_rdata;
  // ALU port
  logic [2:0]            alu_opcode;
  logic [ALU_W-1:0]      alu_op1;
  logic [ALU_W-1:0]      alu_op2;
  logic [ALU_W-1:0]      alu_result;

  modport slave (
    input  start, cmd_opcode, cmd_src_a, cmd_src_b, cmd_dst, mem_rdata, alu_result,
    output busy, done, err, result, mem_addr, mem_wdata, mem_we,
           alu_opcode, alu_op1, alu_op2
  );

  modport master (
    output start, cmd_opcode, cmd_src_a, cmd_src_b, cmd_dst, mem_rdata, alu_result,
    input  busy, done, err, result, mem_addr, mem_wdata, mem_we,
           alu_opcode, alu_op1, alu_op2
  );
endinterface

// File: rtl/alu_mem_controller.sv
// alu_mem_controller: sequences one command as read A, read B, execute,
// write back. Memory read latency is one cycle; the ALU is combinational.
// Optional feature macro: CTRL_READBACK_EN -- re-reads the destination after
// the write and sets a sticky err on mismatch. Without it err is tied 0.
module alu_mem_controller #(
  parameter int MEM_ADDR_W = 4,
  parameter int MEM_DATA_W = 16,
  parameter int ALU_W      = 8
) (
  input logic               clk,
  input logic               rst,
  alu_mem_controller_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, RD_A, RD_B, CAP_B, EXEC, WRITE, VWAIT, VCHK, DONE
  } state_t;

  state_t                state;
  logic [MEM_ADDR_W-1:0] src_b_q;
  logic [MEM_ADDR_W-1:0] dst_q;
  logic                  busy_q;
  logic                  done_q;
  logic [ALU_W-1:0]      result_q;
  logic [MEM_ADDR_W-1:0] mem_addr_q;
  logic [MEM_DATA_W-1:0] mem_wdata_q;
  logic                  mem_we_q;
  logic [2:0]            alu_opcode_q;
  logic [ALU_W-1:0]      alu_op1_q;
  logic [ALU_W-1:0]      alu_op2_q;
`ifdef CTRL_READBACK_EN
  logic                  err_q;
`endif

  // Command FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      src_b_q      <= '0;
      dst_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      alu_opcode_q <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
`ifdef CTRL_READBACK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // src_a goes straight to the address bus; only b and dst are needed later
            src_b_q      <= bus.cmd_src_b;
            dst_q        <= bus.cmd_dst;
            mem_addr_q   <= bus.cmd_src_a;
            alu_opcode_q <= bus.cmd_opcode;
            busy_q       <= 1'b1;
            state        <= RD_A;
          end
        end
        RD_A: begin
          mem_addr_q <= src_b_q;
          state      <= RD_B;
        end
        RD_B: begin
          alu_op1_q <= bus.mem_rdata[ALU_W-1:0];
          state     <= CAP_B;
        end
        CAP_B: begin
          alu_op2_q <= bus.mem_rdata[ALU_W-1:0];
          state     <= EXEC;
        end
        EXEC: begin
          result_q    <= bus.alu_result;
          mem_addr_q  <= dst_q;
          mem_wdata_q <= MEM_DATA_W'(bus.alu_result);
          mem_we_q    <= 1'b1;
          state       <= WRITE;
        end
        WRITE: begin
          mem_we_q <= 1'b0;
`ifdef CTRL_READBACK_EN
          state    <= VWAIT;
`else
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= DONE;
`endif
        end
`ifdef CTRL_READBACK_EN
        // address still dst; memory samples it this cycle
        VWAIT: state <= VCHK;
        VCHK: begin
          if (bus.mem_rdata != MEM_DATA_W'(result_q)) err_q <= 1'b1;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= DONE;
        end
`endif
        // one idle cycle after done; start here is ignored
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_op1    = alu_op1_q;
  assign bus.alu_op2    = alu_op2_q;
`ifdef CTRL_READBACK_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule
